// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared types and constants for the two-requester ALU arbiter:
//   op_e       - ALU operation codes (ADD, SUB, AND, OR)
//   state_e    - arbiter FSM states (IDLE, EXEC, DONE)
//   SEG_*      - seven-segment codes for digits 0..7 and the ovf/unf flags
//   seg_digit  - maps a 3-bit digit to its seven-segment code
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [7:0] SEG_0     = 8'b0011_1111;
    localparam logic [7:0] SEG_1     = 8'b0000_0110;
    localparam logic [7:0] SEG_2     = 8'b0101_1011;
    localparam logic [7:0] SEG_3     = 8'b0100_1111;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b0110_1101;
    localparam logic [7:0] SEG_6     = 8'b0111_1101;
    localparam logic [7:0] SEG_7     = 8'b0000_0111;
    localparam logic [7:0] SEG_OVF   = 8'b1011_1111;
    localparam logic [7:0] SEG_UNF   = 8'b1011_1110;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] seg_digit(input logic [2:0] digit);
        logic [7:0] code;
        case (digit)
            3'd0:    code = SEG_0;
            3'd1:    code = SEG_1;
            3'd2:    code = SEG_2;
            3'd3:    code = SEG_3;
            3'd4:    code = SEG_4;
            3'd5:    code = SEG_5;
            3'd6:    code = SEG_6;
            default: code = SEG_7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational ALU shared by both requesters.
// Ports:
//   op     [1:0]       operation code (op_e encoding)
//   a, b   [NBITS-1:0] unsigned operands
//   result [NBITS-1:0] operation result, modulo 2^NBITS
//   ovf                carry-out of ADD (0 for other ops)
//   unf                borrow of SUB, i.e. a < b (0 for other ops)
// -----------------------------------------------------------------------------
module alu_core
    import alu_arbiter_pkg::*;
#(
    parameter int NBITS = 3
) (
    input  logic [1:0]       op,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic [NBITS-1:0] result,
    output logic             ovf,
    output logic             unf
);

    // One extra bit captures the carry of the sum and the borrow of the
    // difference; the borrow bit is set exactly when a < b.
    logic [NBITS:0] sum;
    logic [NBITS:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        result = '0;
        ovf    = 1'b0;
        unf    = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                result = sum[NBITS-1:0];
                ovf    = sum[NBITS];
            end
            OP_SUB: begin
                result = diff[NBITS-1:0];
                unf    = diff[NBITS];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two requesters share one ALU. A request seen in IDLE is granted for one
// EXEC cycle (round-robin on contention), the result is registered on the
// transition into DONE and held until the next DONE.
// Ports:
//   clk_2            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   req   [NREQ-1:0] per-requester request
//   op0, op1 [1:0]   operation codes (00 add, 01 sub, 10 and, 11 or)
//   a0, b0, a1, b1   unsigned operands, NBITS each
//   gnt   [NREQ-1:0] one-hot grant, high during the EXEC cycle
//   busy             high whenever the FSM is not IDLE
//   res_valid        one-cycle result pulse (DONE cycle)
//   res_id           requester that owns the current result
//   result           registered ALU result
//   ovf, unf         add carry-out / sub borrow flags
//   seg   [7:0]      seven-segment code of the last result
// Configuration:
//   ALU_ARBITER_SEG_EN - when defined, seg is a registered decode of the
//                        result (flags override the digit); otherwise seg
//                        is tied to 8'h00.
// Only NREQ = 2 is supported.
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NBITS = 3,
    parameter int NREQ  = 2
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [1:0]       op0,
    input  logic [1:0]       op1,
    input  logic [NBITS-1:0] a0,
    input  logic [NBITS-1:0] b0,
    input  logic [NBITS-1:0] a1,
    input  logic [NBITS-1:0] b1,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic [NBITS-1:0] result,
    output logic             ovf,
    output logic             unf,
    output logic [7:0]       seg
);

    state_e           state;
    logic             last_served;
    logic             winner_id;

    // Operands captured at grant time so later input changes cannot disturb
    // the operation in flight.
    logic [1:0]       lat_op;
    logic [NBITS-1:0] lat_a;
    logic [NBITS-1:0] lat_b;
    logic             lat_id;

    logic [NBITS-1:0] core_result;
    logic             core_ovf;
    logic             core_unf;

    // Single requester wins outright; on contention the one not served last
    // wins.
    always_comb begin
        winner_id = 1'b0;
        if (req[0] && req[1]) begin
            winner_id = ~last_served;
        end else if (req[1]) begin
            winner_id = 1'b1;
        end
    end

    alu_core #(
        .NBITS (NBITS)
    ) u_alu_core (
        .op     (lat_op),
        .a      (lat_a),
        .b      (lat_b),
        .result (core_result),
        .ovf    (core_ovf),
        .unf    (core_unf)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            gnt         <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
            last_served <= 1'b1;
            lat_op      <= OP_ADD;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_id      <= 1'b0;
        end else begin
            // Pulses default low; only the state that owns them raises them.
            gnt       <= '0;
            res_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state          <= ST_EXEC;
                        busy           <= 1'b1;
                        gnt[winner_id] <= 1'b1;
                        last_served    <= winner_id;
                        lat_id         <= winner_id;
                        lat_op         <= winner_id ? op1 : op0;
                        lat_a          <= winner_id ? a1  : a0;
                        lat_b          <= winner_id ? b1  : b0;
                    end
                end
                ST_EXEC: begin
                    state     <= ST_DONE;
                    res_valid <= 1'b1;
                    res_id    <= lat_id;
                    result    <= core_result;
                    ovf       <= core_ovf;
                    unf       <= core_unf;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ARBITER_SEG_EN
    logic [31:0] core_result_ext;

    assign core_result_ext = 32'(core_result);

    // Updated on the same edge as result/res_valid; results above 7 (only
    // possible with NBITS > 3) have no digit and blank the display.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            seg <= SEG_BLANK;
        end else if (state == ST_EXEC) begin
            if (core_ovf) begin
                seg <= SEG_OVF;
            end else if (core_unf) begin
                seg <= SEG_UNF;
            end else if (core_result_ext < 32'd8) begin
                seg <= seg_digit(core_result_ext[2:0]);
            end else begin
                seg <= SEG_BLANK;
            end
        end
    end
`else
    assign seg = 8'h00;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a table of directed transactions,
// hand-written multi-cycle sequences (round-robin, reset mid-operation,
// request withdrawn before sampling) and randomized transactions checked
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int NBITS = 3;
    localparam int NREQ  = 2;

    logic             clk_2;
    logic             reset_n;
    logic [NREQ-1:0]  req;
    logic [1:0]       op0;
    logic [1:0]       op1;
    logic [NBITS-1:0] a0;
    logic [NBITS-1:0] b0;
    logic [NBITS-1:0] a1;
    logic [NBITS-1:0] b1;
    logic [NREQ-1:0]  gnt;
    logic             busy;
    logic             res_valid;
    logic             res_id;
    logic [NBITS-1:0] result;
    logic             ovf;
    logic             unf;
    logic [7:0]       seg;

    int tests_run;
    int tests_failed;
    int last_served;   // reference model round-robin pointer

    alu_arbiter #(
        .NBITS (NBITS),
        .NREQ  (NREQ)
    ) dut (
        .clk_2     (clk_2),
        .reset_n   (reset_n),
        .req       (req),
        .op0       (op0),
        .op1       (op1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .gnt       (gnt),
        .busy      (busy),
        .res_valid (res_valid),
        .res_id    (res_id),
        .result    (result),
        .ovf       (ovf),
        .unf       (unf),
        .seg       (seg)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    typedef struct {
        string      name;
        logic [1:0] req;
        logic [1:0] op;
        int         a;
        int         b;
        logic [1:0] exp_gnt;
        int         exp_id;
        int         exp_res;
        bit         exp_ovf;
        bit         exp_unf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference ALU: plain integer arithmetic on the operation definitions.
    function automatic void model_alu(input int op, input int a, input int b,
                                      output int res, output bit o, output bit u);
        int m;
        m = 1 << NBITS;
        o = 1'b0;
        u = 1'b0;
        case (op)
            0: begin
                res = (a + b) % m;
                o   = (a + b) >= m;
            end
            1: begin
                res = (a - b + m) % m;
                u   = a < b;
            end
            2:       res = a & b;
            default: res = a | b;
        endcase
    endfunction

    function automatic logic [7:0] seg_model(input int res, input bit o, input bit u);
        logic [7:0] digits [8];
        logic [7:0] code;
        digits = '{8'b0011_1111, 8'b0000_0110, 8'b0101_1011, 8'b0100_1111,
                   8'b0110_0110, 8'b0110_1101, 8'b0111_1101, 8'b0000_0111};
        if (o)           code = 8'b1011_1111;
        else if (u)      code = 8'b1011_1110;
        else if (res < 8) code = digits[res];
        else             code = 8'h00;
`ifdef ALU_ARBITER_SEG_EN
        return code;
`else
        return (code == 8'h00) ? code : 8'h00;
`endif
    endfunction

    // One full transaction: drive in IDLE, check grant, scramble operands
    // during EXEC, check result in DONE, check hold after return to IDLE.
    task automatic txn(input string name, input logic [1:0] r,
                       input logic [1:0] o0, input int a0v, input int b0v,
                       input logic [1:0] o1, input int a1v, input int b1v,
                       input logic [1:0] exp_gnt, input int exp_id,
                       input int exp_res, input bit exp_ovf, input bit exp_unf,
                       input bit hold);
        logic [7:0] exp_seg;
        exp_seg = seg_model(exp_res, exp_ovf, exp_unf);
        @(negedge clk_2);
        req = r;
        op0 = o0; a0 = NBITS'(a0v); b0 = NBITS'(b0v);
        op1 = o1; a1 = NBITS'(a1v); b1 = NBITS'(b1v);
        @(posedge clk_2); #1;
        check({name, ".gnt"},  32'(gnt), 32'(exp_gnt));
        check({name, ".busy"}, 32'(busy), 32'd1);
        check({name, ".rv_early"}, 32'(res_valid), 32'd0);
        if (!hold) req = '0;
        op0 = 2'($urandom); a0 = NBITS'($urandom); b0 = NBITS'($urandom);
        op1 = 2'($urandom); a1 = NBITS'($urandom); b1 = NBITS'($urandom);
        @(posedge clk_2); #1;
        check({name, ".res_valid"}, 32'(res_valid), 32'd1);
        check({name, ".result"}, 32'(result), 32'(exp_res));
        check({name, ".ovf"}, 32'(ovf), 32'(exp_ovf));
        check({name, ".unf"}, 32'(unf), 32'(exp_unf));
        check({name, ".res_id"}, 32'(res_id), 32'(exp_id));
        check({name, ".seg"}, 32'(seg), 32'(exp_seg));
        check({name, ".gnt_off"}, 32'(gnt), 32'd0);
        @(posedge clk_2); #1;
        check({name, ".rv_pulse"}, 32'(res_valid), 32'd0);
        check({name, ".busy_off"}, 32'(busy), 32'd0);
        check({name, ".hold"}, 32'(result), 32'(exp_res));
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".gnt"}, 32'(gnt), 32'd0);
        check({name, ".busy"}, 32'(busy), 32'd0);
        check({name, ".res_valid"}, 32'(res_valid), 32'd0);
        check({name, ".res_id"}, 32'(res_id), 32'd0);
        check({name, ".result"}, 32'(result), 32'd0);
        check({name, ".ovf"}, 32'(ovf), 32'd0);
        check({name, ".unf"}, 32'(unf), 32'd0);
        check({name, ".seg"}, 32'(seg), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        last_served  = 1;
        reset_n = 1'b0;
        req = '0; op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        vecs[0] = '{"add_ovf",  2'b01, 2'b00, 5, 4, 2'b01, 0, 1, 1'b1, 1'b0};
        vecs[1] = '{"sub_unf",  2'b10, 2'b01, 2, 3, 2'b10, 1, 7, 1'b0, 1'b1};
        vecs[2] = '{"or_hold",  2'b01, 2'b11, 4, 1, 2'b01, 0, 5, 1'b0, 1'b0};
        vecs[3] = '{"and_r1",   2'b10, 2'b10, 6, 3, 2'b10, 1, 2, 1'b0, 1'b0};
        vecs[4] = '{"sub_ok",   2'b01, 2'b01, 6, 2, 2'b01, 0, 4, 1'b0, 1'b0};
        vecs[5] = '{"add_ok",   2'b10, 2'b00, 3, 2, 2'b10, 1, 5, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk_2);
        #1;
        check_all_zero("reset");
        @(negedge clk_2);
        reset_n = 1'b1;

        // Directed table; the same operands are offered to both requesters
        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].name, vecs[i].req,
                vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_res,
                vecs[i].exp_ovf, vecs[i].exp_unf, 1'b0);
            last_served = vecs[i].exp_id;
        end

        // Round-robin after reset with both requests held
        @(negedge clk_2);
        reset_n = 1'b0;
        @(negedge clk_2);
        reset_n = 1'b1;
        last_served = 1;
        txn("rr0", 2'b11, 2'b10, 6, 3, 2'b10, 7, 5, 2'b01, 0, 2, 1'b0, 1'b0, 1'b1);
        txn("rr1", 2'b11, 2'b10, 6, 3, 2'b10, 7, 5, 2'b10, 1, 5, 1'b0, 1'b0, 1'b1);
        txn("rr2", 2'b11, 2'b10, 6, 3, 2'b10, 7, 5, 2'b01, 0, 2, 1'b0, 1'b0, 1'b0);
        last_served = 0;

        // Request withdrawn before it is sampled is never served
        @(negedge clk_2);
        req = 2'b01;
        #2 req = 2'b00;
        @(posedge clk_2); #1;
        check("drop.gnt", 32'(gnt), 32'd0);
        check("drop.busy", 32'(busy), 32'd0);
        @(posedge clk_2); #1;
        check("drop.rv", 32'(res_valid), 32'd0);

        // Reset in the middle of EXEC aborts the operation
        txn("pre_rst", 2'b10, 2'b00, 3, 3, 2'b00, 3, 3, 2'b10, 1, 6, 1'b0, 1'b0, 1'b0);
        @(negedge clk_2);
        req = 2'b01; op0 = 2'b00; a0 = 3'd3; b0 = 3'd2;
        @(posedge clk_2); #1;
        check("rst_mid.gnt", 32'(gnt), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        req = '0;
        check_all_zero("rst_mid");
        repeat (2) begin
            @(posedge clk_2); #1;
            check("rst_mid.no_rv", 32'(res_valid), 32'd0);
        end
        @(negedge clk_2);
        reset_n = 1'b1;
        last_served = 1;
        @(posedge clk_2); #1;
        check("post_rst.rv", 32'(res_valid), 32'd0);
        check("post_rst.busy", 32'(busy), 32'd0);
        txn("post_rst", 2'b01, 2'b00, 3, 2, 2'b00, 0, 0, 2'b01, 0, 5, 1'b0, 1'b0, 1'b0);
        last_served = 0;

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [1:0] r, o0, o1, eg;
            int x0, y0, x1, y1, w, er;
            bit eo, eu;
            r  = 2'($urandom_range(1, 3));
            o0 = 2'($urandom); o1 = 2'($urandom);
            x0 = int'($urandom_range(0, 7)); y0 = int'($urandom_range(0, 7));
            x1 = int'($urandom_range(0, 7)); y1 = int'($urandom_range(0, 7));
            if (r == 2'b11)      w = 1 - last_served;
            else if (r == 2'b10) w = 1;
            else                 w = 0;
            last_served = w;
            eg = (w == 1) ? 2'b10 : 2'b01;
            if (w == 1) model_alu(int'(o1), x1, y1, er, eo, eu);
            else        model_alu(int'(o0), x0, y0, er, eo, eu);
            txn($sformatf("rnd%0d", n), r, o0, x0, y0, o1, x1, y1,
                eg, w, er, eo, eu, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NBITS, default 3, operand/result width.
REQ-002 SHALL have parameter NREQ, default 2, number of requesters (only 2 supported).
REQ-003 clk_2  input  1  system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  2  per-requester request, bit i = requester i.
REQ-006 op0, op1  input  2 each  operation code: 00 add, 01 sub, 10 and, 11 or.
REQ-007 a0, b0, a1, b1  input  NBITS each  unsigned operands per requester.
REQ-008 gnt  output  2  one-hot grant pulse, one cycle.
REQ-009 busy  output  1  high whenever FSM not IDLE.
REQ-010 res_valid  output  1  result-valid pulse, one cycle.
REQ-011 res_id  output  1  index of requester owning current result.
REQ-012 result  output  NBITS  registered ALU result.
REQ-013 ovf, unf  output  1 each  add carry-out / sub borrow flags.
REQ-014 seg  output  8  seven-segment code of last result (see Configuration).

Function
REQ-015 FSM SHALL have states IDLE, EXEC, DONE; IDLE->EXEC when any req bit high at clock edge; EXEC->DONE unconditionally; DONE->IDLE unconditionally.
REQ-016 On IDLE->EXEC SHALL latch winner's op/a/b and id; gnt[winner] high exactly during EXEC cycle.
REQ-017 Arbitration: single requester wins; both requesting -> requester not served last wins (round-robin); last_served pointer updates on each grant.
REQ-018 Latency: req sampled at edge N -> gnt high cycle N+1 -> result/flags/res_valid valid cycle N+2; back-to-back grant earliest at cycle N+4 (IDLE revisited).
REQ-019 Requests SHALL be sampled only in IDLE; requester holds req until gnt; req dropped before sampling is not served, no error.
REQ-020 add: result = (a+b) mod 2^NBITS, ovf = carry-out, unf = 0.
REQ-021 sub: result = (a-b) mod 2^NBITS, unf = (a<b), ovf = 0.
REQ-022 and/or: bitwise result, ovf = unf = 0.
REQ-023 result, ovf, unf, res_id SHALL hold their values after DONE until next DONE.
REQ-024 Operand changes after grant SHALL NOT affect in-flight result.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, gnt=0, busy=0, res_valid=0, res_id=0, result=0, ovf=0, unf=0, seg=0, last_served=1 (requester 0 wins first contention).
REQ-026 Reset mid-EXEC/DONE SHALL abort operation with no res_valid pulse; first post-reset req sampled at first rising edge with reset_n high.

Configuration
REQ-027 Macro ALU_ARBITER_SEG_EN defined: seg = registered decode of result, updated with res_valid: 0..7 -> 00111111, 00000110, 01011011, 01001111, 01100110, 01101101, 01111101, 00000111; ovf -> 10111111; unf -> 10111110 (flags override digit).
REQ-028 Macro undefined: seg tied 8'h00, no decoder logic synthesized.

Structure
REQ-029 Shared package alu_arbiter_pkg SHALL hold op enum (ADD, SUB, AND, OR), FSM state enum, seven-segment code constants.
REQ-030 Single sub-module alu_core (combinational op/a/b -> result/ovf/unf) SHALL be instantiated once, fed from latched operands.

Verification
REQ-031 req=01, op0=00, a0=5, b0=4 -> gnt=01 next cycle, then result=1, ovf=1, unf=0, res_id=0, res_valid one pulse.
REQ-032 req=10, op1=01, a1=2, b1=3 -> gnt=10, result=7, unf=1, ovf=0, res_id=1; seg=10111110 with macro, 00 without.
REQ-033 req=11 held, both op=10, a0=6,b0=3, a1=7,b1=5 after reset -> grants 01 then 10 alternating; results 2 then 5.
REQ-034 reset_n pulled low during EXEC -> busy=0, no res_valid, all outputs 0; next req=01 granted normally.
REQ-035 req=01 op0=11 a0=4 b0=1, then operands changed in EXEC cycle -> result=5 unchanged; seg=01101101 with macro.
